// File: rtl/uart_pack_parser.sv
// rtl/uart_pack_parser.sv - UART byte stream to fixed 14-byte command packet decoder
// Validates header and checksum; good frames update the register outputs, bad or stalled frames only count errors.
module uart_pack_parser #(
  parameter logic [7:0] _HEAD0       = 8'h55,
  parameter logic [7:0] _HEAD1       = 8'hAA,
  parameter int         _TIMEOUT_CYC = 50000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] func_reg,
  output logic [7:0] rev_data1,
  output logic [7:0] rev_data2,
  output logic [7:0] rev_data3,
  output logic [7:0] rev_data4,
  output logic [7:0] rev_data5,
  output logic [7:0] rev_data6,
  output logic [7:0] rev_data7,
  output logic [7:0] rev_data8,
  output logic [7:0] rev_data9,
  output logic [7:0] rev_data10,
  output logic       pack_done,
  output logic       sum_err,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(_TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD1,
    S_FUNC,
    S_DATA,
    S_SUM
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      shadow_q [0:10];
  logic [7:0]      shadow_d [0:10];
  logic [7:0]      out_q [0:10];
  logic [7:0]      out_d [0:10];
  logic            pack_done_q, pack_done_d;
  logic            sum_err_q, sum_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 4'd0;
      sum_q         <= 8'h00;
      shadow_q      <= '{default: 8'h00};
      out_q         <= '{default: 8'h00};
      pack_done_q   <= 1'b0;
      sum_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_cnt_q     <= 8'h00;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      pack_done_q   <= pack_done_d;
      sum_err_q     <= sum_err_d;
      timeout_err_q <= timeout_err_d;
      err_cnt_q     <= err_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    pack_done_d   = 1'b0;
    sum_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_cnt_d     = err_cnt_q;
    tmo_cnt_d     = (state_q == S_IDLE || rx_done) ? '0 : tmo_cnt_q + CW'(1);

    if (rx_done) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == _HEAD0) state_d = S_HEAD1;
        end
        S_HEAD1: begin
          // A repeated HEAD0 is treated as the start of a new frame.
          if (rx_data == _HEAD1)      state_d = S_FUNC;
          else if (rx_data != _HEAD0) state_d = S_IDLE;
        end
        S_FUNC: begin
          shadow_d[0] = rx_data;
          sum_d       = rx_data;
          idx_d       = 4'd1;
          state_d     = S_DATA;
        end
        S_DATA: begin
          shadow_d[idx_q] = rx_data;
          sum_d           = sum_q + rx_data;
          if (idx_q == 4'd10) state_d = S_SUM;
          else                idx_d   = idx_q + 4'd1;
        end
        S_SUM: begin
          if (rx_data == sum_q) begin
            out_d       = shadow_q;
            pack_done_d = 1'b1;
          end else begin
            sum_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_cnt_q == CW'(_TIMEOUT_CYC - 1)) begin
      timeout_err_d = 1'b1;
      state_d       = S_IDLE;
    end

    if ((sum_err_d || timeout_err_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign func_reg    = out_q[0];
  assign rev_data1   = out_q[1];
  assign rev_data2   = out_q[2];
  assign rev_data3   = out_q[3];
  assign rev_data4   = out_q[4];
  assign rev_data5   = out_q[5];
  assign rev_data6   = out_q[6];
  assign rev_data7   = out_q[7];
  assign rev_data8   = out_q[8];
  assign rev_data9   = out_q[9];
  assign rev_data10  = out_q[10];
  assign pack_done   = pack_done_q;
  assign sum_err     = sum_err_q;
  assign timeout_err = timeout_err_q;
  assign err_cnt     = err_cnt_q;

endmodule
